// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding, error data
// default and the wait-counter width.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ERRRESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mmio_addr_match.sv
// Address decoder for one slave window: hit when BASE <= byte_addr < BASE + SIZE.
module mmio_addr_match #(
  parameter logic [31:0] BASE = 32'd0,
  parameter logic [31:0] SIZE = 32'd4
) (
  input  logic [31:0] byte_addr,
  output logic        hit
);

  // Compared at 33 bits so a window ending exactly at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + {1'b0, SIZE};

  assign hit = (byte_addr >= BASE) && ({1'b0, byte_addr} < LIMIT);

endmodule

// File: rtl/mmio_interconnect.sv
// Single-master MMIO interconnect: decodes the address to one slave, tracks the
// handshake with a wait timeout and records the first bus error address.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned                 N_SLAVES   = 4,
  parameter logic [32*N_SLAVES-1:0]      SLAVE_BASE = {32'd3072, 32'd1032, 32'd1028, 32'd1024},
  parameter logic [32*N_SLAVES-1:0]      SLAVE_SIZE = {32'd1024, 32'd4, 32'd4, 32'd4},
  parameter int unsigned                 TIMEOUT    = 255,
  parameter logic [31:0]                 ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [29:0]              m_addr,
  input  logic [3:0]               m_sel,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic                     m_ack,
  output logic [N_SLAVES-1:0]      s_req,
  output logic                     s_we,
  output logic [29:0]              s_addr,
  output logic [3:0]               s_sel,
  output logic [31:0]              s_wdata,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ack,
  output logic                     err,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic [31:0]        byte_addr_s;
  logic [N_SLAVES-1:0] hit_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic               hit_any_s;
  logic               err_set_s;
  logic [31:0]        slave_rdata_s [N_SLAVES];

  assign byte_addr_s = {m_addr, 2'b00};
  assign s_we        = m_we;
  assign s_addr      = m_addr;
  assign s_sel       = m_sel;
  assign s_wdata     = m_wdata;
  assign err         = err_q;
  assign err_addr    = err_addr_q;

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_slave
    mmio_addr_match #(
      .BASE (SLAVE_BASE[32*g +: 32]),
      .SIZE (SLAVE_SIZE[32*g +: 32])
    ) u_match (
      .byte_addr (byte_addr_s),
      .hit       (hit_s[g])
    );
    assign slave_rdata_s[g] = s_rdata[32*g +: 32];
  end

  // Priority encoder: scanning downwards leaves the lowest hit index.
  always_comb begin
    hit_idx_s = {IDX_W{1'b0}};
    hit_any_s = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        hit_idx_s = IDX_W'(i);
        hit_any_s = 1'b1;
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  // Handshake FSM, slave request steering, read data mux and error capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_set_s  = 1'b0;
    s_req      = {N_SLAVES{1'b0}};
    m_ack      = 1'b0;
    m_rdata    = 32'd0;
    if (rst) begin
      m_ack = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_req && hit_any_s) begin
            s_req[hit_idx_s] = 1'b1;
            if (s_ack[hit_idx_s]) begin
              m_ack   = 1'b1;
              m_rdata = m_we ? 32'd0 : slave_rdata_s[hit_idx_s];
            end else begin
              state_d = ST_WAIT;
              idx_d   = hit_idx_s;
              cnt_d   = {CNT_W{1'b0}};
            end
          end else if (m_req) begin
            state_d = ST_ERRRESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A real ack outranks a timeout landing in the same cycle.
          if (s_ack[idx_q]) begin
            m_ack   = 1'b1;
            m_rdata = m_we ? 32'd0 : slave_rdata_s[idx_q];
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else if (cnt_q == CNT_LAST) begin
            m_ack     = 1'b1;
            m_rdata   = m_we ? 32'd0 : ERR_DATA;
            err_set_s = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_ERRRESP: begin
          m_ack     = 1'b1;
          m_rdata   = m_we ? 32'd0 : ERR_DATA;
          err_set_s = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase

      // A clear arriving with a new error re-arms capture for that error.
      if (err_set_s) begin
        err_d = 1'b1;
        if (!err_q || err_clr) begin
          err_addr_d = byte_addr_s;
        end else begin
          err_addr_d = err_addr_q;
        end
      end else if (err_clr) begin
        err_d = 1'b0;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect with TIMEOUT=4; slaves are driven by hand.
module tb_mmio_interconnect;

  logic         clk;
  logic         rst;
  logic         m_req;
  logic         m_we;
  logic [29:0]  m_addr;
  logic [3:0]   m_sel;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic         m_ack;
  logic [3:0]   s_req;
  logic         s_we;
  logic [29:0]  s_addr;
  logic [3:0]   s_sel;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic         err;
  logic [31:0]  err_addr;
  logic         err_clr;

  int checks_cnt = 0;
  int errors_cnt = 0;

  mmio_interconnect #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_sel(m_sel), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack), .err(err),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_master();
    m_req   = 1'b0;
    m_we    = 1'b0;
    s_ack   = 4'b0000;
    err_clr = 1'b0;
  endtask

  task automatic start(input logic we, input logic [31:0] byte_addr);
    m_req  = 1'b1;
    m_we   = we;
    m_addr = byte_addr[31:2];
  endtask

  initial begin
    rst     = 1'b1;
    m_sel   = 4'hF;
    m_wdata = 32'h0;
    s_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    idle_master();
    // Request with a zero-wait ack while in reset must stay invisible.
    start(1'b0, 32'h0000_0C00);
    s_ack = 4'b1000;
    sample();
    check("rst_ack", {31'd0, m_ack}, 32'd0);
    check("rst_sreq", {28'd0, s_req}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_eaddr", err_addr, 32'd0);

    // Zero-wait read of slave 3.
    tick(); rst = 1'b0;
    start(1'b0, 32'h0000_0C00);
    s_ack = 4'b1000;
    sample();
    check("zw_ack", {31'd0, m_ack}, 32'd1);
    check("zw_rdata", m_rdata, 32'h33333333);
    check("zw_sreq", {28'd0, s_req}, 32'h8);
    tick(); idle_master();
    sample();
    check("zw_sreq_off", {28'd0, s_req}, 32'd0);
    check("zw_ack_off", {31'd0, m_ack}, 32'd0);

    // Write to slave 1, acked three cycles later; a stray slave-0 ack is ignored.
    tick();
    start(1'b1, 32'h0000_0404);
    m_wdata = 32'hA5A55A5A;
    sample();
    check("wr_sreq0", {28'd0, s_req}, 32'h2);
    check("wr_swe", {31'd0, s_we}, 32'd1);
    check("wr_swdata", s_wdata, 32'hA5A55A5A);
    check("wr_saddr", {2'b00, s_addr}, 32'h101);
    check("wr_ack0", {31'd0, m_ack}, 32'd0);
    tick(); sample();
    check("wr_sreq1", {28'd0, s_req}, 32'd0);
    check("wr_ack1", {31'd0, m_ack}, 32'd0);
    tick(); s_ack = 4'b0001; sample();
    check("wr_other_ack", {31'd0, m_ack}, 32'd0);
    tick(); s_ack = 4'b0010; sample();
    check("wr_ack3", {31'd0, m_ack}, 32'd1);
    check("wr_rdata", m_rdata, 32'd0);
    tick(); idle_master(); sample();
    check("wr_err", {31'd0, err}, 32'd0);

    // Unmapped read: two-cycle error response.
    tick(); start(1'b0, 32'h0000_0200); sample();
    check("um_sreq", {28'd0, s_req}, 32'd0);
    check("um_ack0", {31'd0, m_ack}, 32'd0);
    tick(); sample();
    check("um_ack1", {31'd0, m_ack}, 32'd1);
    check("um_rdata", m_rdata, 32'hDEADBEEF);
    tick(); idle_master(); sample();
    check("um_err", {31'd0, err}, 32'd1);
    check("um_eaddr", err_addr, 32'h200);
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0; sample();
    check("um_clr", {31'd0, err}, 32'd0);
    check("um_eaddr_kept", err_addr, 32'h200);

    // Timeout on slave 2: ack on the fourth WAIT cycle.
    tick(); start(1'b0, 32'h0000_0408); sample();
    check("to_sreq", {28'd0, s_req}, 32'h4);
    for (int c = 1; c <= 3; c++) begin
      tick(); sample();
      check("to_wait_ack", {31'd0, m_ack}, 32'd0);
    end
    tick(); sample();
    check("to_ack", {31'd0, m_ack}, 32'd1);
    check("to_rdata", m_rdata, 32'hDEADBEEF);
    tick(); idle_master(); sample();
    check("to_err", {31'd0, err}, 32'd1);
    check("to_eaddr", err_addr, 32'h408);

    // Second error keeps the first address.
    tick(); start(1'b0, 32'h0000_0300);
    tick(); sample();
    check("e2_ack", {31'd0, m_ack}, 32'd1);
    tick(); idle_master(); sample();
    check("e2_eaddr", err_addr, 32'h408);
    check("e2_err", {31'd0, err}, 32'd1);

    // Clear coinciding with a new error: err stays set, address updates.
    tick(); start(1'b0, 32'h0000_0100);
    tick(); err_clr = 1'b1; sample();
    check("e3_ack", {31'd0, m_ack}, 32'd1);
    tick(); idle_master(); sample();
    check("e3_err", {31'd0, err}, 32'd1);
    check("e3_eaddr", err_addr, 32'h100);
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0; sample();
    check("e3_clr", {31'd0, err}, 32'd0);

    // Ack and timeout in the same cycle: ack wins.
    tick(); start(1'b0, 32'h0000_0408);
    tick(); tick(); tick();
    tick(); s_ack = 4'b0100; sample();
    check("race_ack", {31'd0, m_ack}, 32'd1);
    check("race_rdata", m_rdata, 32'h22222222);
    tick(); idle_master(); sample();
    check("race_err", {31'd0, err}, 32'd0);

    // Timeout on slave 1, then a late ack with no request is ignored.
    tick(); start(1'b0, 32'h0000_0404);
    tick(); tick(); tick();
    tick(); sample();
    check("late_to_ack", {31'd0, m_ack}, 32'd1);
    tick(); idle_master(); s_ack = 4'b0010; sample();
    check("late_ignored", {31'd0, m_ack}, 32'd0);
    check("late_err", {31'd0, err}, 32'd1);

    // Reset while in WAIT: no ack, back to IDLE, late ack ignored, err cleared.
    tick(); idle_master(); start(1'b0, 32'h0000_0404); sample();
    check("rw_sreq", {28'd0, s_req}, 32'h2);
    tick(); rst = 1'b1; s_ack = 4'b0010; sample();
    check("rw_rst_ack", {31'd0, m_ack}, 32'd0);
    tick(); rst = 1'b0; m_req = 1'b0; s_ack = 4'b0010; sample();
    check("rw_late_ack", {31'd0, m_ack}, 32'd0);
    check("rw_err", {31'd0, err}, 32'd0);
    check("rw_eaddr", err_addr, 32'd0);
    tick(); idle_master(); start(1'b0, 32'h0000_0404); sample();
    check("rw_reissue", {28'd0, s_req}, 32'h2);
    tick(); s_ack = 4'b0010; sample();
    check("rw_reissue_ack", {31'd0, m_ack}, 32'd1);
    check("rw_reissue_data", m_rdata, 32'h11111111);
    tick(); idle_master();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/mmio_interconnect.md
MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of slave ports (1..16).
REQ-002 SHALL have parameter SLAVE_BASE, default {32'd3072, 32'd1032, 32'd1028, 32'd1024}: packed byte base address per slave; slave i occupies bits [32i+31:32i].
REQ-003 SHALL have parameter SLAVE_SIZE, default {32'd1024, 32'd4, 32'd4, 32'd4}: packed byte size per slave, power of two, at least 4.
REQ-004 SHALL have parameter TIMEOUT, default 255: wait cycles before a bus error is returned (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on error.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port m_req, input, 1: master request; held high until m_ack.
REQ-009 SHALL have port m_we, input, 1: master request is a write.
REQ-010 SHALL have port m_addr, input, 30: word address; byte address is {m_addr, 2'b00}.
REQ-011 SHALL have port m_sel, input, 4: byte lane enables.
REQ-012 SHALL have port m_wdata, input, 32: write data.
REQ-013 SHALL have port m_rdata, output, 32: read data, valid when m_ack and !m_we.
REQ-014 SHALL have port m_ack, output, 1: one-cycle completion pulse.
REQ-015 SHALL have ports s_req (output, N_SLAVES) and s_we (output, 1), plus s_addr (output, 30), s_sel (output, 4) and s_wdata (output, 32), all broadcast from the master.
REQ-016 SHALL have ports s_rdata (input, 32*N_SLAVES) and s_ack (input, N_SLAVES).
REQ-017 SHALL have ports err (output, 1, sticky bus error), err_addr (output, 32, byte address of the first error) and err_clr (input, 1).

Function
REQ-018 Slave i SHALL be hit when SLAVE_BASE_i <= {m_addr, 2'b00} < SLAVE_BASE_i + SLAVE_SIZE_i; the lowest index wins on overlap.
REQ-019 The FSM SHALL have three states: IDLE, WAIT and ERRRESP.
REQ-020 In IDLE with m_req high and slave i hit, s_req[i] SHALL be m_req, combinationally, for exactly that one cycle; other s_req bits SHALL stay 0.
REQ-021 If s_ack[i] is high in that same cycle, m_ack SHALL assert combinationally and the FSM SHALL stay in IDLE (zero-wait slave).
REQ-022 Otherwise the FSM SHALL latch i and go to WAIT with the wait counter at 0; s_req SHALL stay low for the whole of WAIT.
REQ-023 In WAIT, s_ack[latched i] SHALL produce m_ack that cycle and a return to IDLE; acks from other slaves SHALL be ignored.
REQ-024 In WAIT, the counter SHALL increment each cycle; when the counter equals TIMEOUT-1 with no ack, m_ack SHALL pulse with m_rdata=ERR_DATA, err SHALL set, and the FSM SHALL return to IDLE.
REQ-025 If the ack and the timeout land in the same cycle, the ack SHALL win and no error SHALL be flagged.
REQ-026 In IDLE with m_req high and no hit, no s_req SHALL assert; the FSM SHALL go to ERRRESP, then pulse m_ack the next cycle with ERR_DATA for reads, set err, and return to IDLE (total latency 2 cycles).
REQ-027 An s_ack that arrives after a timeout SHALL be ignored unless it coincides with a new s_req to the same slave.
REQ-028 m_rdata SHALL be s_rdata of the acking slave on a successful read ack, ERR_DATA on an error ack, and 0 otherwise.
REQ-029 err_addr SHALL capture the byte address only when err is 0 (first error wins).
REQ-030 err_clr SHALL clear err; if err_clr and a new error occur in the same cycle, err SHALL stay 1 and err_addr SHALL update.
REQ-031 Writes SHALL use the identical handshake; m_rdata SHALL be 0 on write acks.

Reset
REQ-032 While rst is high, the FSM SHALL be IDLE, the counter 0, the latched index 0, err 0, err_addr 0, m_ack 0 and s_req 0, even if a transaction is in flight; the master SHALL reissue the request afterwards.

Structure
REQ-033 A shared package mmio_pkg SHALL hold the FSM state encoding, the ERR_DATA default and the counter width constant (16).
REQ-034 One sub-module, mmio_addr_match (base, size -> hit), SHALL be instantiated once per slave by a generate loop.

Verification
REQ-035 Read of 0xC00 with slave 3 s_ack in the same cycle -> m_ack in the same cycle, m_rdata = slave 3 data, s_req = 4'b1000 for 1 cycle.
REQ-036 Write to 0x404 with slave 1 acking 3 cycles later -> s_req[1] pulses once, m_ack after 3 cycles, err = 0.
REQ-037 Read of 0x200 (unmapped) -> no s_req, m_ack 2 cycles later, m_rdata = 0xDEADBEEF, err = 1, err_addr = 0x200.
REQ-038 Read of 0x408 with TIMEOUT=4 and no ack -> m_ack after 4 WAIT cycles with 0xDEADBEEF, err = 1; a second error at 0x300 leaves err_addr = 0x408; err_clr -> err = 0.
REQ-039 Ack and timeout in the same cycle -> valid data, err = 0; rst asserted in WAIT -> IDLE next cycle, no m_ack, and a later late s_ack is ignored.
